// File: rtl/udp_word_unpack_pkg.sv
// rtl/udp_word_unpack_pkg.sv - shared constants, FSM states and nibble selector for the word unpacker
// Purpose: default sizing, unpack FSM state encoding and the nibble ordering helper.
// Contents: UNPACK_DEPTH, UNPACK_PKT_WORDS, UNPACK_TIMEOUT, unpack_state_t, nibble_sel().
package udp_word_unpack_pkg;

  localparam int UNPACK_DEPTH     = 4;
  localparam int UNPACK_PKT_WORDS = 256;
  localparam int UNPACK_TIMEOUT   = 1024;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } unpack_state_t;

  // Mirror of the receive-side packer: high byte goes first, low nibble of
  // each byte first, so a packed-then-unpacked word is bit-identical.
  function automatic logic [3:0] nibble_sel(input logic [15:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    nibble_sel = word[11:8];
      2'd1:    nibble_sel = word[15:12];
      2'd2:    nibble_sel = word[3:0];
      default: nibble_sel = word[7:4];
    endcase
  endfunction

endpackage

// File: rtl/udp_word_unpack_if.sv
// rtl/udp_word_unpack_if.sv - system word input and FIFO nibble output bundle
// Purpose: groups the upstream word handshake and the FIFO write side.
// Signals: sys_data/sys_en/sys_ready (word in), fifo_data/fifo_wr/fifo_full (nibble out).
// Modports: master drives words and the full flag; slave is the unpacker.
interface udp_word_unpack_if;
  logic [15:0] sys_data;
  logic        sys_en;
  logic        sys_ready;
  logic [3:0]  fifo_data;
  logic        fifo_wr;
  logic        fifo_full;

  modport master (
    output sys_data, sys_en, fifo_full,
    input  sys_ready, fifo_data, fifo_wr
  );

  modport slave (
    input  sys_data, sys_en, fifo_full,
    output sys_ready, fifo_data, fifo_wr
  );
endinterface

// File: rtl/udp_word_unpack_buf.sv
// rtl/udp_word_unpack_buf.sv - DEPTH x 16 circular word buffer with drop counter
// Purpose: absorbs upstream words while the unpacker shifts nibbles out.
// Ports: phy_clk_rx/rst_n; i_data/i_en word offer; i_pop head consume;
//        o_head head word; o_count occupancy; o_ready accept flag; o_drop_cnt saturating drops.
module unpack_word_buf
  import udp_word_unpack_pkg::*;
#(
  parameter int DEPTH = UNPACK_DEPTH
) (
  input  logic                     phy_clk_rx,
  input  logic                     rst_n,
  input  logic [15:0]              i_data,
  input  logic                     i_en,
  input  logic                     i_pop,
  output logic [15:0]              o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_ready,
  output logic [7:0]               o_drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_drop_cnt;
  logic          w_push;
  logic          w_pop;

  // Ready looks only at the registered count, so a pop in the same cycle
  // never frees a slot for a word offered while full; held low in reset.
  assign o_ready    = rst_n && (r_count < L_FULL);
  assign w_push     = i_en && o_ready;
  assign w_pop      = i_pop && (r_count != '0);
  assign o_head     = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_drop_cnt = r_drop_cnt;

  always_ff @(posedge phy_clk_rx or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_en && !o_ready && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/udp_word_unpack.sv
// rtl/udp_word_unpack.sv - 16-bit word to 4-bit nibble unpacker feeding the UDP transmit FIFO
// Purpose: buffers words, emits one nibble per cycle to the FIFO, and requests a
//          UDP send after PKT_WORDS words or after TIMEOUT idle cycles.
// Ports: phy_clk_rx/rst_n; bus (slave: word in, nibble out, fifo_full);
//        frame_go single-cycle send request; drop_cnt saturating dropped-word count.
module udp_word_unpack
  import udp_word_unpack_pkg::*;
#(
  parameter int DEPTH     = UNPACK_DEPTH,
  parameter int PKT_WORDS = UNPACK_PKT_WORDS,
  parameter int TIMEOUT   = UNPACK_TIMEOUT
) (
  input  logic              phy_clk_rx,
  input  logic              rst_n,
  udp_word_unpack_if.slave  bus,
  output logic              frame_go,
  output logic [7:0]        drop_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);

  unpack_state_t r_state, w_state_nxt;
  logic [15:0]   r_shift, w_shift_nxt, w_head;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [3:0]    r_fifo_data, w_fifo_data_nxt;
  logic          r_fifo_wr, w_fifo_wr_nxt;
  logic          w_pop, w_last_wr;
  logic [CW-1:0] w_count;
  logic          w_sys_ready, w_push, w_idle;
  logic [7:0]    w_drop_cnt;
  logic [15:0]   r_frame_cnt, w_frame_inc;
  logic          r_pkt_hit, r_frame_go;
  logic [TW-1:0] r_timer;

  unpack_word_buf #(.DEPTH(DEPTH)) u_buf (
    .phy_clk_rx (phy_clk_rx),
    .rst_n      (rst_n),
    .i_data     (bus.sys_data),
    .i_en       (bus.sys_en),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_ready    (w_sys_ready),
    .o_drop_cnt (w_drop_cnt)
  );

  assign bus.sys_ready = w_sys_ready;
  assign bus.fifo_data = r_fifo_data;
  assign bus.fifo_wr   = r_fifo_wr;
  assign frame_go      = r_frame_go;
  assign drop_cnt      = w_drop_cnt;
  assign w_push        = bus.sys_en && w_sys_ready;
  assign w_frame_inc   = r_frame_cnt + 16'd1;
  assign w_idle        = (r_state == ST_IDLE) && (w_count == '0) && (r_frame_cnt != 16'd0);

  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_idx_nxt       = r_idx;
    w_fifo_data_nxt = r_fifo_data;
    w_fifo_wr_nxt   = 1'b0;
    w_pop           = 1'b0;
    w_last_wr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_count != '0) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_idx_nxt   = 2'd0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A full FIFO simply freezes idx; the nibble is retried next cycle.
        if (!bus.fifo_full) begin
          w_fifo_wr_nxt   = 1'b1;
          w_fifo_data_nxt = nibble_sel(r_shift, r_idx);
          w_idx_nxt       = r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            w_last_wr = 1'b1;
            // Reload straight from the buffer so back-to-back words have no bubble.
            if (w_count != '0) begin
              w_pop       = 1'b1;
              w_shift_nxt = w_head;
              w_idx_nxt   = 2'd0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge phy_clk_rx or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_fifo_data <= '0;
      r_fifo_wr   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_idx       <= w_idx_nxt;
      r_fifo_data <= w_fifo_data_nxt;
      r_fifo_wr   <= w_fifo_wr_nxt;
    end
  end

  // Frame completion is pipelined one extra stage so frame_go lands in the
  // cycle after the last nibble's fifo_wr. The idle timer fires on the edge
  // where it would reach TIMEOUT-1; it only runs in IDLE, so the two
  // frame_go sources never overlap.
  always_ff @(posedge phy_clk_rx or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_pkt_hit   <= 1'b0;
      r_frame_go  <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_pkt_hit  <= 1'b0;
      r_frame_go <= r_pkt_hit;
      if (w_last_wr) begin
        if (w_frame_inc == 16'(PKT_WORDS)) begin
          r_frame_cnt <= '0;
          r_pkt_hit   <= 1'b1;
        end else begin
          r_frame_cnt <= w_frame_inc;
        end
      end
      if (w_idle && !w_push) begin
        if (r_timer == TW'(TIMEOUT - 2)) begin
          r_timer     <= '0;
          r_frame_cnt <= '0;
          r_frame_go  <= 1'b1;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end else begin
        r_timer <= '0;
      end
    end
  end
endmodule
